// File: rtl/z80_sram_responder_if.sv
// Physical-side Z80 memory bus and SRAM control strobes between the CPU/MMU side
// and the SRAM responder. The two 8-bit data buses stay plain inout ports.
interface z80_sram_responder_if #(
    parameter int PA_W = 20
);
    logic            nMREQ;
    logic            nRD;
    logic            nWR;
    logic [PA_W-1:0] physical_addr;
    logic            nWAIT;
    logic [PA_W-1:0] sram_addr;
    logic            sram_nCE;
    logic            sram_nOE;
    logic            sram_nWE;
    logic            proto_err;

    modport master (
        output nMREQ, nRD, nWR, physical_addr,
        input  nWAIT, sram_addr, sram_nCE, sram_nOE, sram_nWE, proto_err
    );

    modport slave (
        input  nMREQ, nRD, nWR, physical_addr,
        output nWAIT, sram_addr, sram_nCE, sram_nOE, sram_nWE, proto_err
    );
endinterface

// File: rtl/z80_sram_responder.sv
// Services translated Z80 memory cycles on an external asynchronous SRAM,
// stretching the CPU cycle through nWAIT until the timed SRAM cycle finishes.
module z80_sram_responder #(
    parameter int PA_W       = 20,
    parameter int SETUP_CYC  = 1,
    parameter int ACCESS_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic                 CLK,
    input  logic                 nRESET,
    z80_sram_responder_if.slave  bus,
    inout  wire  [7:0]           ram_data,
    inout  wire  [7:0]           sram_dq
);

    localparam int CNT_MAX = (SETUP_CYC > ACCESS_CYC)
                           ? ((SETUP_CYC  > HOLD_CYC) ? SETUP_CYC  : HOLD_CYC)
                           : ((ACCESS_CYC > HOLD_CYC) ? ACCESS_CYC : HOLD_CYC);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] ACCESS_LOAD = CNT_W'(ACCESS_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_HOLD   = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    logic            mreq_meta_r, mreq_sync_r;
    logic            rd_meta_r,   rd_sync_r;
    logic            wr_meta_r,   wr_sync_r;

    state_e          state_r, state_nx;
    logic [CNT_W-1:0] cnt_r, cnt_nx;
    logic            is_write_r, write_nx;
    logic            abort_r, abort_nx;
    logic            armed_r, armed_nx;
    logic [PA_W-1:0] sram_addr_r;
    logic [7:0]      wdata_r;
    logic [7:0]      rdata_r;
    logic            nwait_r, nwait_nx;
    logic            nce_r, nce_nx;
    logic            noe_r, noe_nx;
    logic            nwe_r, nwe_nx;
    logic            dq_oe_r, dq_oe_nx;
    logic            rd_drive_r, rd_drive_nx;
    logic            proto_err_r, proto_err_nx;

    logic            req_s;
    logic            err_s;
    logic            accept_s;
    logic            capture_s;
    logic            active_nx_s;

    // Two-flop synchronisers for the asynchronous Z80 strobes (idle high)
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            mreq_meta_r <= 1'b1;
            mreq_sync_r <= 1'b1;
            rd_meta_r   <= 1'b1;
            rd_sync_r   <= 1'b1;
            wr_meta_r   <= 1'b1;
            wr_sync_r   <= 1'b1;
        end else begin
            mreq_meta_r <= bus.nMREQ;
            mreq_sync_r <= mreq_meta_r;
            rd_meta_r   <= bus.nRD;
            rd_sync_r   <= rd_meta_r;
            wr_meta_r   <= bus.nWR;
            wr_sync_r   <= wr_meta_r;
        end
    end

    // armed_r demands nMREQ be seen high between services, so one CPU cycle is
    // never serviced twice and a protocol error is flagged only once.
    assign req_s = armed_r & ~mreq_sync_r & (rd_sync_r ^ wr_sync_r);
    assign err_s = armed_r & ~mreq_sync_r & ~rd_sync_r & ~wr_sync_r;

    // Next-state, counter and control decode
    always_comb begin
        state_nx     = state_r;
        cnt_nx       = cnt_r;
        write_nx     = is_write_r;
        abort_nx     = abort_r;
        armed_nx     = armed_r | mreq_sync_r;
        nwait_nx     = nwait_r;
        rd_drive_nx  = 1'b0;
        proto_err_nx = 1'b0;
        accept_s     = 1'b0;
        capture_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_s) begin
                    state_nx = ST_SETUP;
                    cnt_nx   = SETUP_LOAD;
                    write_nx = ~wr_sync_r;
                    abort_nx = 1'b0;
                    armed_nx = 1'b0;
                    nwait_nx = 1'b0;
                    accept_s = 1'b1;
                end else if (err_s) begin
                    proto_err_nx = 1'b1;
                    armed_nx     = 1'b0;
                    nwait_nx     = 1'b1;
                end else begin
                    nwait_nx = 1'b1;
                end
            end
            ST_SETUP: begin
                abort_nx = abort_r | mreq_sync_r;
                if (cnt_r == CNT_ZERO) begin
                    state_nx = ST_ACCESS;
                    cnt_nx   = ACCESS_LOAD;
                end else begin
                    cnt_nx = cnt_r - CNT_ONE;
                end
            end
            ST_ACCESS: begin
                abort_nx = abort_r | mreq_sync_r;
                if (cnt_r == CNT_ZERO) begin
                    state_nx  = ST_HOLD;
                    cnt_nx    = HOLD_LOAD;
                    capture_s = ~is_write_r;
                end else begin
                    cnt_nx = cnt_r - CNT_ONE;
                end
            end
            ST_HOLD: begin
                abort_nx = abort_r | mreq_sync_r;
                if (cnt_r == CNT_ZERO) begin
                    // An abandoned cycle still runs to completion, then skips DONE
                    if (abort_r || mreq_sync_r) begin
                        state_nx = ST_IDLE;
                    end else begin
                        state_nx = ST_DONE;
                    end
                end else begin
                    cnt_nx = cnt_r - CNT_ONE;
                end
            end
            ST_DONE: begin
                nwait_nx = 1'b1;
                if (mreq_sync_r) begin
                    state_nx = ST_IDLE;
                end else begin
                    rd_drive_nx = ~is_write_r;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                cnt_nx   = CNT_ZERO;
                nwait_nx = 1'b1;
            end
        endcase
    end

    // SRAM strobes are decoded from the next state so they register in step with it
    always_comb begin
        active_nx_s = (state_nx == ST_SETUP) || (state_nx == ST_ACCESS) || (state_nx == ST_HOLD);
        nce_nx      = ~active_nx_s;
        noe_nx      = ~((state_nx == ST_ACCESS) && !write_nx);
        nwe_nx      = ~((state_nx == ST_ACCESS) && write_nx);
        dq_oe_nx    = active_nx_s && write_nx;
    end

    // FSM state, counter and cycle bookkeeping
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_r    <= ST_IDLE;
            cnt_r      <= CNT_ZERO;
            is_write_r <= 1'b0;
            abort_r    <= 1'b0;
            armed_r    <= 1'b0;
        end else begin
            state_r    <= state_nx;
            cnt_r      <= cnt_nx;
            is_write_r <= write_nx;
            abort_r    <= abort_nx;
            armed_r    <= armed_nx;
        end
    end

    // Registered outputs and bus-facing enables
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            nwait_r     <= 1'b1;
            nce_r       <= 1'b1;
            noe_r       <= 1'b1;
            nwe_r       <= 1'b1;
            dq_oe_r     <= 1'b0;
            rd_drive_r  <= 1'b0;
            proto_err_r <= 1'b0;
        end else begin
            nwait_r     <= nwait_nx;
            nce_r       <= nce_nx;
            noe_r       <= noe_nx;
            nwe_r       <= nwe_nx;
            dq_oe_r     <= dq_oe_nx;
            rd_drive_r  <= rd_drive_nx;
            proto_err_r <= proto_err_nx;
        end
    end

    // Address and data latches; sram_addr holds its value between cycles
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            sram_addr_r <= {PA_W{1'b0}};
            wdata_r     <= 8'h00;
            rdata_r     <= 8'h00;
        end else begin
            if (accept_s) begin
                sram_addr_r <= bus.physical_addr;
            end
            if (accept_s && !wr_sync_r) begin
                wdata_r <= ram_data;
            end
            if (capture_s) begin
                rdata_r <= sram_dq;
            end
        end
    end

    assign bus.nWAIT     = nwait_r;
    assign bus.sram_addr = sram_addr_r;
    assign bus.sram_nCE  = nce_r;
    assign bus.sram_nOE  = noe_r;
    assign bus.sram_nWE  = nwe_r;
    assign bus.proto_err = proto_err_r;

    // Read data is offered only while the CPU still holds its raw read strobe
    assign ram_data = (rd_drive_r && !bus.nRD) ? rdata_r : 8'hzz;
    assign sram_dq  = dq_oe_r ? wdata_r : 8'hzz;

endmodule

// File: tb/tb_z80_sram_responder.sv
// Directed bench for z80_sram_responder: write, read, refresh, protocol error,
// abort, back-to-back reads and asynchronous reset in the middle of a write.
module tb_z80_sram_responder;

    logic       CLK = 1'b0;
    logic       nRESET;
    wire  [7:0] ram_data;
    wire  [7:0] sram_dq;
    logic       tb_ram_oe;
    logic [7:0] tb_ram_q;
    logic [7:0] mem [0:255];
    logic       model_wr_en;
    int         n_checks;
    int         n_fail;

    z80_sram_responder_if #(.PA_W(20)) sif ();

    z80_sram_responder #(
        .PA_W(20), .SETUP_CYC(1), .ACCESS_CYC(2), .HOLD_CYC(1)
    ) dut (
        .CLK      (CLK),
        .nRESET   (nRESET),
        .bus      (sif),
        .ram_data (ram_data),
        .sram_dq  (sram_dq)
    );

    always #5 CLK = ~CLK;

    // Released buses float high so an undriven bus reads 8'hFF
    pullup pu_ram (ram_data);
    pullup pu_dq  (sram_dq);

    assign ram_data = tb_ram_oe ? tb_ram_q : 8'hzz;
    assign sram_dq  = (!sif.sram_nCE && !sif.sram_nOE) ? mem[sif.sram_addr[7:0]] : 8'hzz;

    // SRAM model stores the data bus on the rising edge of nWE
    always @(posedge sif.sram_nWE) begin
        if (model_wr_en && !sif.sram_nCE) mem[sif.sram_addr[7:0]] = sram_dq;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic bus_idle();
        sif.nMREQ = 1'b1;
        sif.nRD   = 1'b1;
        sif.nWR   = 1'b1;
        tb_ram_oe = 1'b0;
    endtask

    task automatic do_read(input logic [19:0] addr, output logic [7:0] data, output bit timeout);
        bit seen_low;
        int n;
        seen_low = 1'b0;
        n = 0;
        sif.physical_addr = addr;
        sif.nMREQ = 1'b0;
        sif.nRD   = 1'b0;
        while (!seen_low && n < 20) begin
            tick(); n++;
            if (sif.nWAIT === 1'b0) seen_low = 1'b1;
        end
        while (seen_low && sif.nWAIT !== 1'b1 && n < 40) begin
            tick(); n++;
        end
        timeout = !seen_low || (sif.nWAIT !== 1'b1);
        data = ram_data;
        sif.nMREQ = 1'b1;
        repeat (3) tick();
        sif.nRD = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_reset();
        nRESET = 1'b1;
        bus_idle();
        sif.physical_addr = 20'h00000;
        tb_ram_q = 8'h00;
        #1 nRESET = 1'b0;
        #1;
        n_checks++; if (sif.nWAIT !== 1'b1) begin n_fail++; $display("FAIL reset_nwait: got %b expected 1", sif.nWAIT); end
        n_checks++; if ({sif.sram_nCE, sif.sram_nOE, sif.sram_nWE} !== 3'b111) begin n_fail++; $display("FAIL reset_strobes: got %b expected 111", {sif.sram_nCE, sif.sram_nOE, sif.sram_nWE}); end
        n_checks++; if (sif.sram_addr !== 20'h00000) begin n_fail++; $display("FAIL reset_addr: got %h expected 00000", sif.sram_addr); end
        n_checks++; if (sif.proto_err !== 1'b0) begin n_fail++; $display("FAIL reset_proto_err: got %b expected 0", sif.proto_err); end
        n_checks++; if ({ram_data, sram_dq} !== 16'hFFFF) begin n_fail++; $display("FAIL reset_buses_released: got %h/%h expected ff/ff", ram_data, sram_dq); end
        repeat (3) tick();
        nRESET = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_write();
        int nwait_lo, nce_lo, noe_lo, nwe_lo, dq_bad, addr_bad;
        nwait_lo = 0; nce_lo = 0; noe_lo = 0; nwe_lo = 0; dq_bad = 0; addr_bad = 0;
        sif.physical_addr = 20'h8E0FF;
        tb_ram_q  = 8'h7F;
        tb_ram_oe = 1'b1;
        sif.nMREQ = 1'b0;
        sif.nWR   = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (sif.nWAIT === 1'b0) nwait_lo++;
            if (sif.sram_nCE === 1'b0) nce_lo++;
            if (sif.sram_nOE === 1'b0) noe_lo++;
            if (sif.sram_nWE === 1'b0) begin
                nwe_lo++;
                if (sram_dq !== 8'h7F) dq_bad++;
                if (sif.sram_addr !== 20'h8E0FF) addr_bad++;
            end
        end
        bus_idle();
        repeat (4) tick();
        n_checks++; if (nwait_lo !== 5) begin n_fail++; $display("FAIL write_nwait_len: got %0d expected 5", nwait_lo); end
        n_checks++; if (nce_lo !== 4) begin n_fail++; $display("FAIL write_nce_len: got %0d expected 4", nce_lo); end
        n_checks++; if (nwe_lo !== 2) begin n_fail++; $display("FAIL write_nwe_len: got %0d expected 2", nwe_lo); end
        n_checks++; if (noe_lo !== 0) begin n_fail++; $display("FAIL write_noe_len: got %0d expected 0", noe_lo); end
        n_checks++; if (dq_bad !== 0) begin n_fail++; $display("FAIL write_dq: %0d bad samples expected 0", dq_bad); end
        n_checks++; if (addr_bad !== 0) begin n_fail++; $display("FAIL write_addr: %0d bad samples expected 0", addr_bad); end
        n_checks++; if (mem[8'hFF] !== 8'h7F) begin n_fail++; $display("FAIL write_stored: got %h expected 7f", mem[8'hFF]); end
    endtask

    task automatic test_read();
        int nwait_lo, noe_lo, nwe_lo, early;
        nwait_lo = 0; noe_lo = 0; nwe_lo = 0; early = 0;
        sif.physical_addr = 20'h000AC;
        sif.nMREQ = 1'b0;
        sif.nRD   = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (sif.sram_nOE === 1'b0) noe_lo++;
            if (sif.sram_nWE === 1'b0) nwe_lo++;
            if (sif.nWAIT === 1'b0) begin
                nwait_lo++;
                if (ram_data !== 8'hFF) early++;
            end
        end
        n_checks++; if (noe_lo !== 2) begin n_fail++; $display("FAIL read_noe_len: got %0d expected 2", noe_lo); end
        n_checks++; if (nwe_lo !== 0) begin n_fail++; $display("FAIL read_nwe_len: got %0d expected 0", nwe_lo); end
        n_checks++; if (nwait_lo !== 5) begin n_fail++; $display("FAIL read_nwait_len: got %0d expected 5", nwait_lo); end
        n_checks++; if (early !== 0) begin n_fail++; $display("FAIL read_early_drive: %0d samples expected 0", early); end
        n_checks++; if (ram_data !== 8'hA5) begin n_fail++; $display("FAIL read_data: got %h expected a5", ram_data); end
        sif.nMREQ = 1'b1;
        repeat (4) tick();
        n_checks++; if (ram_data !== 8'hFF) begin n_fail++; $display("FAIL read_release: got %h expected ff", ram_data); end
        sif.nRD = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_refresh();
        int nce_lo, nwait_lo;
        nce_lo = 0; nwait_lo = 0;
        sif.physical_addr = 20'h55555;
        sif.nMREQ = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (sif.sram_nCE === 1'b0) nce_lo++;
            if (sif.nWAIT === 1'b0) nwait_lo++;
        end
        bus_idle();
        repeat (3) tick();
        n_checks++; if (nce_lo !== 0) begin n_fail++; $display("FAIL refresh_nce: got %0d expected 0", nce_lo); end
        n_checks++; if (nwait_lo !== 0) begin n_fail++; $display("FAIL refresh_nwait: got %0d expected 0", nwait_lo); end
        n_checks++; if (sif.sram_addr !== 20'h000AC) begin n_fail++; $display("FAIL refresh_addr_hold: got %h expected 000ac", sif.sram_addr); end
    endtask

    task automatic test_error();
        int perr, nce_lo, strobe_lo, nwait_lo;
        for (int rep = 0; rep < 2; rep++) begin
            perr = 0; nce_lo = 0; strobe_lo = 0; nwait_lo = 0;
            sif.physical_addr = 20'h00010;
            sif.nMREQ = 1'b0;
            sif.nRD   = 1'b0;
            sif.nWR   = 1'b0;
            for (int i = 0; i < 10; i++) begin
                tick();
                if (sif.proto_err === 1'b1) perr++;
                if (sif.sram_nCE === 1'b0) nce_lo++;
                if (sif.sram_nOE === 1'b0 || sif.sram_nWE === 1'b0) strobe_lo++;
                if (sif.nWAIT === 1'b0) nwait_lo++;
            end
            bus_idle();
            repeat (3) tick();
            n_checks++; if (perr !== 1) begin n_fail++; $display("FAIL error_pulse[%0d]: got %0d cycles expected 1", rep, perr); end
            n_checks++; if (nce_lo + strobe_lo !== 0) begin n_fail++; $display("FAIL error_no_sram[%0d]: got %0d strobe cycles expected 0", rep, nce_lo + strobe_lo); end
            n_checks++; if (nwait_lo !== 0) begin n_fail++; $display("FAIL error_nwait[%0d]: got %0d expected 0", rep, nwait_lo); end
        end
    endtask

    task automatic test_abort();
        int n, nwe_lo, driven, dq_bad;
        n = 0; nwe_lo = 0; driven = 0; dq_bad = 0;
        sif.physical_addr = 20'h12345;
        tb_ram_q  = 8'h5A;
        tb_ram_oe = 1'b1;
        sif.nMREQ = 1'b0;
        sif.nWR   = 1'b0;
        while (sif.sram_nWE !== 1'b0 && n < 10) begin tick(); n++; end
        n_checks++; if (sif.sram_nWE !== 1'b0) begin n_fail++; $display("FAIL abort_start: nWE %b expected 0 within 10 cycles", sif.sram_nWE); end
        if (sif.sram_nWE === 1'b0) nwe_lo++;
        bus_idle();
        for (int i = 0; i < 10; i++) begin
            tick();
            if (sif.sram_nWE === 1'b0) begin
                nwe_lo++;
                if (sram_dq !== 8'h5A) dq_bad++;
            end
            if (ram_data !== 8'hFF) driven++;
        end
        n_checks++; if (nwe_lo !== 2) begin n_fail++; $display("FAIL abort_nwe_len: got %0d expected 2", nwe_lo); end
        n_checks++; if (dq_bad !== 0) begin n_fail++; $display("FAIL abort_dq: %0d bad samples expected 0", dq_bad); end
        n_checks++; if (driven !== 0) begin n_fail++; $display("FAIL abort_ram_data: %0d driven samples expected 0", driven); end
        n_checks++; if ({sif.nWAIT, sif.sram_nCE} !== 2'b11) begin n_fail++; $display("FAIL abort_idle: nWAIT/nCE %b expected 11", {sif.nWAIT, sif.sram_nCE}); end
        n_checks++; if (mem[8'h45] !== 8'h5A) begin n_fail++; $display("FAIL abort_stored: got %h expected 5a", mem[8'h45]); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        bit         to;
        do_read(20'h8E0FF, d, to);
        n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL b2b_timeout0: got %b expected 0", to); end
        n_checks++; if (d !== 8'h7F) begin n_fail++; $display("FAIL b2b_data0: got %h expected 7f", d); end
        do_read(20'h12345, d, to);
        n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL b2b_timeout1: got %b expected 0", to); end
        n_checks++; if (d !== 8'h5A) begin n_fail++; $display("FAIL b2b_data1: got %h expected 5a", d); end
    endtask

    task automatic test_reset_mid_write();
        int n;
        n = 0;
        model_wr_en = 1'b0;
        sif.physical_addr = 20'h00F00;
        tb_ram_q  = 8'hC3;
        tb_ram_oe = 1'b1;
        sif.nMREQ = 1'b0;
        sif.nWR   = 1'b0;
        while (sif.sram_nWE !== 1'b0 && n < 10) begin tick(); n++; end
        n_checks++; if (sif.sram_nWE !== 1'b0) begin n_fail++; $display("FAIL rstmid_start: nWE %b expected 0 within 10 cycles", sif.sram_nWE); end
        #2 nRESET = 1'b0;
        #1;
        n_checks++; if ({sif.sram_nWE, sif.sram_nCE, sif.sram_nOE} !== 3'b111) begin n_fail++; $display("FAIL rstmid_strobes: got %b expected 111", {sif.sram_nWE, sif.sram_nCE, sif.sram_nOE}); end
        n_checks++; if (sif.nWAIT !== 1'b1) begin n_fail++; $display("FAIL rstmid_nwait: got %b expected 1", sif.nWAIT); end
        n_checks++; if (sram_dq !== 8'hFF) begin n_fail++; $display("FAIL rstmid_dq: got %h expected ff", sram_dq); end
        bus_idle();
        repeat (2) tick();
        nRESET = 1'b1;
        repeat (3) tick();
        n_checks++; if (sif.sram_addr !== 20'h00000) begin n_fail++; $display("FAIL rstmid_addr: got %h expected 00000", sif.sram_addr); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        model_wr_en = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'hAC] = 8'hA5;
        test_reset();
        model_wr_en = 1'b1;
        test_write();
        test_read();
        test_refresh();
        test_error();
        test_abort();
        test_back_to_back();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
